// File: rtl/rx_crc_check_wide_if.sv
// Beat stream, verdict and counter bundle between the rx alignment logic,
// the FCS checker and the frame-status/statistics logic.
interface rx_crc_check_wide_if #(
  parameter int DATA_BYTES = 8,
  parameter int CNT_WIDTH  = 16
);
  localparam int LANE_W = $clog2(DATA_BYTES);

  logic [8*DATA_BYTES-1:0] data_in;
  logic                    data_valid;
  logic                    sof;
  logic                    eof;
  logic [LANE_W-1:0]       eof_lane;
  logic                    abort;
  logic                    cnt_clr;

  logic                    crc_busy;
  logic                    crc_done;
  logic                    crc_ok;
  logic                    crc_bad;
  logic [15:0]             frame_len;
  logic [CNT_WIDTH-1:0]    good_cnt;
  logic [CNT_WIDTH-1:0]    bad_cnt;

  // Upstream side: drives beats and counter clear, observes the verdict.
  modport master (
    output data_in, data_valid, sof, eof, eof_lane, abort, cnt_clr,
    input  crc_busy, crc_done, crc_ok, crc_bad, frame_len, good_cnt, bad_cnt
  );

  // Checker side.
  modport slave (
    input  data_in, data_valid, sof, eof, eof_lane, abort, cnt_clr,
    output crc_busy, crc_done, crc_ok, crc_bad, frame_len, good_cnt, bad_cnt
  );
endinterface

// File: rtl/rx_crc_check_wide.sv
// Wide receive FCS checker: folds a whole DATA_BYTES beat (or the partial
// final beat) into a non-reflected CRC-32 register per cycle, then reports
// a one-cycle good/bad verdict with frame length and saturating counters.
module rx_crc_check_wide #(
  parameter int          DATA_BYTES = 8,
  parameter int          LANE_W     = $clog2(DATA_BYTES),
  parameter logic [31:0] RESIDUE    = 32'hC704DD7B,
  parameter int          CNT_WIDTH  = 16
) (
  input logic              rxclk,
  input logic              reset,
  rx_crc_check_wide_if.slave rx
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_ACCUM  = 2'd1;
  localparam logic [1:0]  ST_REPORT = 2'd2;
  localparam logic [31:0] POLY      = 32'h04C11DB7;
  localparam logic [31:0] SEED      = 32'hFFFFFFFF;

  // One byte into the register, bit 0 of the byte first (wire order).
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_len(input logic [15:0] base, input logic [15:0] add);
    logic [16:0] s;
    s = {1'b0, base} + {1'b0, add};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Stage 1 registers
  logic [8*DATA_BYTES-1:0] data_p1_d, data_p1_q;
  logic [LANE_W-1:0]       lane_p1_d, lane_p1_q;
  logic                    vld_p1_d, vld_p1_q;
  logic                    sof_p1_d, sof_p1_q;
  logic                    eof_p1_d, eof_p1_q;
  logic                    abort_p1_d, abort_p1_q;

  // Stage 2 state and verdict registers
  logic [1:0]              state_d, state_q;
  logic [31:0]             crc_d, crc_q;
  logic [15:0]             len_d, len_q;
  logic                    crc_done_d, crc_done_q;
  logic                    crc_ok_d, crc_ok_q;
  logic                    crc_bad_d, crc_bad_q;
  logic [15:0]             frame_len_d, frame_len_q;
  logic [CNT_WIDTH-1:0]    good_d, good_q;
  logic [CNT_WIDTH-1:0]    bad_d, bad_q;

  logic                    take, start, load;
  logic [31:0]             chain_crc, tail_crc, full_crc;
  logic [15:0]             beat_len;

  // ---- stage 0 -> 1: capture the beat; markers only count on valid beats
  // Qualify markers with data_valid so stage 2 never sees a stray sof/eof.
  always_comb begin
    data_p1_d  = rx.data_in;
    lane_p1_d  = rx.eof_lane;
    vld_p1_d   = rx.data_valid;
    sof_p1_d   = rx.data_valid & rx.sof;
    eof_p1_d   = rx.data_valid & rx.eof;
    abort_p1_d = rx.abort;
  end

  // ---- stage 1 -> 2: byte-step chain, lane mux, FSM and length
  // Fold all lanes in one cycle and tap the chain after eof_lane+1 bytes.
  always_comb begin
    take      = vld_p1_q & ~abort_p1_q;
    start     = take & sof_p1_q;
    load      = start | (take & (state_q == ST_ACCUM));
    chain_crc = sof_p1_q ? SEED : crc_q;
    tail_crc  = SEED;
    for (int i = 0; i < DATA_BYTES; i++) begin
      chain_crc = crc_byte(chain_crc, data_p1_q[8*i +: 8]);
      if (lane_p1_q == LANE_W'(i)) tail_crc = chain_crc;
    end
    full_crc  = chain_crc;
    beat_len  = eof_p1_q ? (16'(lane_p1_q) + 16'd1) : 16'(DATA_BYTES);

    crc_d   = crc_q;
    len_d   = len_q;
    state_d = state_q;
    if (load) begin
      crc_d = eof_p1_q ? tail_crc : full_crc;
      len_d = sat_len(sof_p1_q ? 16'd0 : len_q, beat_len);
    end
    case (state_q)
      ST_IDLE:   if (start) state_d = eof_p1_q ? ST_REPORT : ST_ACCUM;
      // A sof here restarts from the seed; the old frame is simply dropped.
      ST_ACCUM:  if (abort_p1_q)          state_d = ST_IDLE;
                 else if (take & eof_p1_q) state_d = ST_REPORT;
      // The verdict goes out regardless; a following sof beat starts the next frame.
      ST_REPORT: if (start) state_d = eof_p1_q ? ST_REPORT : ST_ACCUM;
                 else       state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---- stage 2 -> 3: verdict strobe and saturating counters
  // Verdict is judged on the register while in REPORT, so a back-to-back load does not disturb it.
  always_comb begin
    crc_done_d  = (state_q == ST_REPORT);
    crc_ok_d    = crc_done_d & (crc_q == RESIDUE);
    crc_bad_d   = crc_done_d & (crc_q != RESIDUE);
    frame_len_d = crc_done_d ? len_q : 16'd0;
    good_d      = good_q;
    bad_d       = bad_q;
    if (rx.cnt_clr) begin
      good_d = '0;
      bad_d  = '0;
    end else begin
      if (crc_done_q & crc_ok_q)  good_d = sat_inc(good_q);
      if (crc_done_q & crc_bad_q) bad_d  = sat_inc(bad_q);
    end
  end

  // Datapath registers need no reset; every use is preceded by a qualified load.
  always_ff @(posedge rxclk) begin
    data_p1_q <= data_p1_d;
    lane_p1_q <= lane_p1_d;
    len_q     <= len_d;
  end

  // Control, CRC and output registers with async reset.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      vld_p1_q    <= 1'b0;
      sof_p1_q    <= 1'b0;
      eof_p1_q    <= 1'b0;
      abort_p1_q  <= 1'b0;
      state_q     <= ST_IDLE;
      crc_q       <= SEED;
      crc_done_q  <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_bad_q   <= 1'b0;
      frame_len_q <= 16'd0;
      good_q      <= '0;
      bad_q       <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      sof_p1_q    <= sof_p1_d;
      eof_p1_q    <= eof_p1_d;
      abort_p1_q  <= abort_p1_d;
      state_q     <= state_d;
      crc_q       <= crc_d;
      crc_done_q  <= crc_done_d;
      crc_ok_q    <= crc_ok_d;
      crc_bad_q   <= crc_bad_d;
      frame_len_q <= frame_len_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
    end
  end

  assign rx.crc_busy  = (state_q == ST_ACCUM);
  assign rx.crc_done  = crc_done_q;
  assign rx.crc_ok    = crc_ok_q;
  assign rx.crc_bad   = crc_bad_q;
  assign rx.frame_len = frame_len_q;
  assign rx.good_cnt  = good_q;
  assign rx.bad_cnt   = bad_q;

endmodule

// File: tb/tb_rx_crc_check_wide.sv
// Directed bench for rx_crc_check_wide: an 8-byte-wide instance for frame
// handling and a 4-byte-wide instance with 2-bit counters for saturation.
module tb_rx_crc_check_wide;

  logic rxclk = 1'b0;
  logic reset = 1'b1;
  always #5 rxclk = ~rxclk;

  rx_crc_check_wide_if #(.DATA_BYTES(8), .CNT_WIDTH(16)) rx8();
  rx_crc_check_wide_if #(.DATA_BYTES(4), .CNT_WIDTH(2))  rx4();

  rx_crc_check_wide #(.DATA_BYTES(8), .CNT_WIDTH(16)) u_dut8 (.rxclk(rxclk), .reset(reset), .rx(rx8));
  rx_crc_check_wide #(.DATA_BYTES(4), .CNT_WIDTH(2))  u_dut4 (.rxclk(rxclk), .reset(reset), .rx(rx4));

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int eof_cyc = 0;

  logic [7:0] frm [0:255];

  // Strobe observers
  int         done8_n = 0, done8_cyc = 0, prev_done8_cyc = 0;
  logic       ok8_last = 1'b0, bad8_last = 1'b0;
  logic [15:0] len8_last = 16'd0;
  logic [7:0] hist8 = 8'd0;
  int         done4_n = 0;
  logic       ok4_last = 1'b0, bad4_last = 1'b0;
  logic [15:0] len4_last = 16'd0;

  always @(posedge rxclk) cyc <= cyc + 1;

  always @(negedge rxclk) begin
    if (rx8.crc_done) begin
      done8_n        <= done8_n + 1;
      ok8_last       <= rx8.crc_ok;
      bad8_last      <= rx8.crc_bad;
      len8_last      <= rx8.frame_len;
      hist8          <= {hist8[6:0], rx8.crc_ok};
      prev_done8_cyc <= done8_cyc;
      done8_cyc      <= cyc;
    end
    if (rx4.crc_done) begin
      done4_n   <= done4_n + 1;
      ok4_last  <= rx4.crc_ok;
      bad4_last <= rx4.crc_bad;
      len4_last <= rx4.frame_len;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Standard Ethernet FCS, reflected shift-right form, complemented.
  function automatic logic [31:0] eth_fcs(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic idle_inputs();
    rx8.data_valid = 1'b0; rx8.sof = 1'b0; rx8.eof = 1'b0; rx8.abort = 1'b0;
    rx4.data_valid = 1'b0; rx4.sof = 1'b0; rx4.eof = 1'b0; rx4.abort = 1'b0;
  endtask

  task automatic drive(input int w, input logic [127:0] bd, input bit s, input bit e,
                       input int lane, input bit ab);
    idle_inputs();
    if (w == 8) begin
      rx8.data_valid = 1'b1; rx8.data_in = bd[63:0]; rx8.sof = s; rx8.eof = e;
      rx8.eof_lane = 3'(lane); rx8.abort = ab;
    end else begin
      rx4.data_valid = 1'b1; rx4.data_in = bd[31:0]; rx4.sof = s; rx4.eof = e;
      rx4.eof_lane = 2'(lane); rx4.abort = ab;
    end
  endtask

  task automatic settle(input int k);
    repeat (k) begin
      @(negedge rxclk);
      idle_inputs();
    end
  endtask

  // Build an n-byte frame (payload + correct FCS, optional bit-3 flip) and
  // send it; optionally stop after stop_beat (with or without abort).
  task automatic send(input int w, input int n, input int flip, input int stop_beat,
                      input bit stop_abort, input bit abort_eof, input int gap_beat,
                      input int gap_n);
    logic [31:0]  fcs;
    logic [127:0] bd;
    int           nb;
    for (int i = 0; i < n - 4; i++) frm[i] = 8'(i * 13 + 5);
    fcs = eth_fcs(n - 4);
    for (int i = 0; i < 4; i++) frm[n - 4 + i] = fcs[8*i +: 8];
    if (flip >= 0) frm[flip] = frm[flip] ^ 8'h08;
    nb = (n + w - 1) / w;
    for (int b = 0; b < nb; b++) begin
      if (b == gap_beat) settle(gap_n);
      @(negedge rxclk);
      bd = '0;
      for (int i = 0; i < w; i++) if (b * w + i < n) bd[8*i +: 8] = frm[b * w + i];
      drive(w, bd, b == 0, b == nb - 1, (n - 1) % w,
            (b == stop_beat && stop_abort) || (b == nb - 1 && abort_eof));
      eof_cyc = cyc;
      if (b == stop_beat) break;
    end
  endtask

  int d;
  int lens4 [5] = '{64, 61, 62, 63, 64};

  initial begin
    idle_inputs();
    rx8.data_in = '0; rx8.eof_lane = '0; rx8.cnt_clr = 1'b0;
    rx4.data_in = '0; rx4.eof_lane = '0; rx4.cnt_clr = 1'b0;
    repeat (3) @(negedge rxclk);
    chk("rst_busy", rx8.crc_busy, 0);
    chk("rst_done", rx8.crc_done, 0);
    chk("rst_ok", rx8.crc_ok, 0);
    chk("rst_bad", rx8.crc_bad, 0);
    chk("rst_len", rx8.frame_len, 0);
    chk("rst_good", rx8.good_cnt, 0);
    chk("rst_badcnt", rx8.bad_cnt, 0);
    chk("rst_good4", rx4.good_cnt, 0);
    reset = 1'b0;
    settle(2);

    // 64-byte good frame, latency and counters
    d = done8_n;
    send(8, 64, -1, -1, 0, 0, -1, 0);
    chk("t1_busy", rx8.crc_busy, 1);
    settle(4);
    chk("t1_done", done8_n - d, 1);
    chk("t1_ok", ok8_last, 1);
    chk("t1_bad", bad8_last, 0);
    chk("t1_len", len8_last, 64);
    chk("t1_lat", done8_cyc - eof_cyc, 3);
    chk("t1_good", rx8.good_cnt, 1);
    chk("t1_badcnt", rx8.bad_cnt, 0);
    chk("t1_idle", rx8.crc_busy, 0);

    // 61-byte good frame with a 3-cycle gap
    d = done8_n;
    send(8, 61, -1, -1, 0, 0, 4, 3);
    settle(4);
    chk("t2_done", done8_n - d, 1);
    chk("t2_ok", ok8_last, 1);
    chk("t2_len", len8_last, 61);
    chk("t2_good", rx8.good_cnt, 2);

    // Corrupted 64-byte frame
    d = done8_n;
    send(8, 64, 20, -1, 0, 0, -1, 0);
    settle(4);
    chk("t3_done", done8_n - d, 1);
    chk("t3_bad", bad8_last, 1);
    chk("t3_ok", ok8_last, 0);
    chk("t3_badcnt", rx8.bad_cnt, 1);
    chk("t3_good", rx8.good_cnt, 2);

    // Counter clear
    @(negedge rxclk); rx8.cnt_clr = 1'b1;
    @(negedge rxclk); rx8.cnt_clr = 1'b0;
    chk("clr_good", rx8.good_cnt, 0);
    chk("clr_bad", rx8.bad_cnt, 0);

    // Back-to-back: good then corrupted
    d = done8_n;
    send(8, 64, -1, -1, 0, 0, -1, 0);
    send(8, 64, 5, -1, 0, 0, -1, 0);
    settle(4);
    chk("b2b_done", done8_n - d, 2);
    chk("b2b_order", hist8[1:0], 2'b10);
    chk("b2b_gap", done8_cyc - prev_done8_cyc, 8);
    chk("b2b_good", rx8.good_cnt, 1);
    chk("b2b_bad", rx8.bad_cnt, 1);

    // Abort on 4th beat, then a good frame
    d = done8_n;
    send(8, 64, -1, 3, 1, 0, -1, 0);
    settle(2);
    chk("ab_busy", rx8.crc_busy, 0);
    send(8, 64, -1, -1, 0, 0, -1, 0);
    settle(4);
    chk("ab_done", done8_n - d, 1);
    chk("ab_ok", ok8_last, 1);
    chk("ab_good", rx8.good_cnt, 2);

    // Abort coincident with eof
    d = done8_n;
    send(8, 64, -1, -1, 0, 1, -1, 0);
    settle(5);
    chk("abeof_done", done8_n - d, 0);
    chk("abeof_busy", rx8.crc_busy, 0);

    // Single-beat frame (sof and eof together)
    d = done8_n;
    send(8, 8, -1, -1, 0, 0, -1, 0);
    settle(4);
    chk("one_done", done8_n - d, 1);
    chk("one_ok", ok8_last, 1);
    chk("one_len", len8_last, 8);

    // sof while accumulating drops the partial frame
    d = done8_n;
    send(8, 64, -1, 3, 0, 0, -1, 0);
    send(8, 61, -1, -1, 0, 0, -1, 0);
    settle(4);
    chk("restart_done", done8_n - d, 1);
    chk("restart_ok", ok8_last, 1);
    chk("restart_len", len8_last, 61);
    chk("restart_good", rx8.good_cnt, 4);

    // 4-byte instance: all lane positions, saturation at 3
    d = done4_n;
    for (int f = 0; f < 5; f++) begin
      send(4, lens4[f], -1, -1, 0, 0, -1, 0);
      settle(4);
      chk("w4_ok", ok4_last, 1);
      chk("w4_len", len4_last, 16'(lens4[f]));
    end
    chk("w4_done", done4_n - d, 5);
    chk("w4_sat", rx4.good_cnt, 3);
    send(4, 64, 9, -1, 0, 0, -1, 0);
    settle(4);
    chk("w4_badv", bad4_last, 1);
    chk("w4_badcnt", rx4.bad_cnt, 1);
    @(negedge rxclk); rx4.cnt_clr = 1'b1;
    @(negedge rxclk); rx4.cnt_clr = 1'b0;
    chk("w4_clr", rx4.good_cnt, 0);
    send(4, 64, -1, -1, 0, 0, -1, 0);
    settle(4);
    chk("w4_one", rx4.good_cnt, 1);
    d = done4_n;
    send(4, 64, -1, -1, 0, 0, -1, 0);
    settle(3);
    rx4.cnt_clr = 1'b1;
    @(negedge rxclk); rx4.cnt_clr = 1'b0;
    chk("w4_clrwin_done", done4_n - d, 1);
    chk("w4_clrwin", rx4.good_cnt, 0);

    // Reset mid-frame
    send(8, 64, -1, 3, 0, 0, -1, 0);
    chk("mrst_busy_pre", rx8.crc_busy, 1);
    reset = 1'b1;
    settle(1);
    chk("mrst_busy", rx8.crc_busy, 0);
    chk("mrst_good", rx8.good_cnt, 0);
    reset = 1'b0;
    d = done8_n;
    send(8, 64, -1, -1, 0, 0, -1, 0);
    settle(4);
    chk("mrst_done", done8_n - d, 1);
    chk("mrst_ok", ok8_last, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
